// File: rtl/data_memory_stall_if.sv
// Request/response bundle between the MEM stage and the multi-cycle data memory.
interface data_memory_stall_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_i;
    logic              we_i;
    logic [1:0]        size_i;
    logic              unsigned_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              ack_o;
    logic              err_o;
    logic              busy_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        input  rdata_o, ack_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        output rdata_o, ack_o, err_o, busy_o
    );
endinterface

// File: rtl/data_memory_stall.sv
// Byte-addressed little-endian data memory with fixed access latency, req/ack handshake,
// byte/half/word sizing with load extension, misalignment detection and a pipeline stall.
module data_memory_stall #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LATENCY     = 2
) (
    input logic                clk_i,
    input logic                rst_i,
    data_memory_stall_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_d;
    logic            w_commit;

    logic            r_we;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic [7:0]      r_mem [DEPTH_BYTES];

    logic [AW-1:0]   w_in_idx;
    logic            w_we;
    logic [1:0]      w_size;
    logic            w_uns;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_wdata;
    logic            w_misalign;
    logic [2:0]      w_nbytes;
    logic [7:0]      w_b0, w_b1, w_b2, w_b3;
    logic [31:0]     w_load;

    // Modulo keeps every address bit in the expression; reduces to a bit select.
    assign w_in_idx = AW'(bus.addr_i % ADDR_W'(DEPTH_BYTES));

    // With LATENCY = 1 the commit happens on the accepting edge, so use live inputs there.
    assign w_we    = (r_state == StIdle) ? bus.we_i       : r_we;
    assign w_size  = (r_state == StIdle) ? bus.size_i     : r_size;
    assign w_uns   = (r_state == StIdle) ? bus.unsigned_i : r_uns;
    assign w_idx   = (r_state == StIdle) ? w_in_idx       : r_idx;
    assign w_wdata = (r_state == StIdle) ? bus.wdata_i    : r_wdata;

    assign w_misalign = (w_size == 2'b11) ||
                        (w_size == 2'b01 && w_idx[0]) ||
                        (w_size == 2'b10 && w_idx[1:0] != 2'b00);

    always_comb begin
        w_nbytes = 3'd0;
        unique case (w_size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            2'b10:   w_nbytes = 3'd4;
            default: w_nbytes = 3'd0;
        endcase
    end

    assign w_b0 = r_mem[w_idx];
    assign w_b1 = r_mem[w_idx + AW'(1)];
    assign w_b2 = r_mem[w_idx + AW'(2)];
    assign w_b3 = r_mem[w_idx + AW'(3)];

    always_comb begin
        w_load = 32'd0;
        unique case (w_size)
            2'b00:   w_load = {{24{~w_uns & w_b0[7]}}, w_b0};
            2'b01:   w_load = {{16{~w_uns & w_b1[7]}}, w_b1, w_b0};
            2'b10:   w_load = {w_b3, w_b2, w_b1, w_b0};
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_commit  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.req_i) begin
                    if (LATENCY == 1) begin
                        w_state_d = StAck;
                        w_commit  = 1'b1;
                    end else begin
                        w_state_d = StWait;
                        w_cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (r_cnt == CW'(1)) begin
                    w_state_d = StAck;
                    w_cnt_d   = '0;
                    w_commit  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - CW'(1);
                end
            end
            StAck:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_err   <= w_commit && w_misalign;
            if (r_state == StIdle && bus.req_i) begin
                r_we    <= bus.we_i;
                r_size  <= bus.size_i;
                r_uns   <= bus.unsigned_i;
                r_idx   <= w_in_idx;
                r_wdata <= bus.wdata_i;
            end
            if (w_commit) begin
                r_rdata <= (w_we || w_misalign) ? 32'd0 : w_load;
            end
        end
    end

    // Reset on the commit edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_commit && w_we && !w_misalign) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < w_nbytes) begin
                    r_mem[w_idx + AW'(k)] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.rdata_o = r_rdata;
    assign bus.ack_o   = (r_state == StAck);
    assign bus.err_o   = r_err;
    assign bus.busy_o  = (r_state == StIdle && bus.req_i) || (r_state == StWait);

endmodule
